// File: rtl/cnt_sched.sv
// Two-requester round-robin run scheduler: the winner owns a shared counter
// for a latched number of cycles, then receives a one-cycle done pulse.
module cnt_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] cnt,
  output logic             cnt_valid,
  output logic [1:0]       done,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ptr;
  logic             r_winner;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_len_q;

  logic             w_winner;
  logic [WIDTH-1:0] w_sel_len;
  logic             w_last;
  logic             w_end_run;

  // Pointer holder wins if requesting; otherwise the other requester does.
  assign w_winner  = req[r_ptr] ? r_ptr : ~r_ptr;
  assign w_sel_len = w_winner ? len1 : len0;
  assign w_last    = (r_cnt == (r_len_q - WIDTH'(1)));
  assign w_end_run = abort || w_last;

  always_comb begin
    w_next_state = r_state;
    gnt          = 2'b00;
    done         = 2'b00;
    cnt_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_next_state = (w_sel_len != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        gnt       = r_winner ? 2'b10 : 2'b01;
        cnt_valid = 1'b1;
        if (w_end_run) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = r_winner ? 2'b10 : 2'b01;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign cnt         = cnt_valid ? r_cnt : '0;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= 1'b0;
      r_winner <= 1'b0;
      r_cnt    <= '0;
      r_len_q  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_winner <= w_winner;
            r_len_q  <= w_sel_len;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          if (!w_end_run) begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        S_DONE: begin
          r_ptr <= ~r_winner;
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// Bench for cnt_sched: timeline-based reference model feeds an expected queue,
// an independent monitor compares every presented output cycle.
module tb_cnt_sched;

  localparam int W = 8;
  localparam int EW = 14; // {gnt[1:0], busy, cnt_valid, done[1:0], cnt[7:0]}

  logic         clk;
  logic         reset_n;
  logic [1:0]   req;
  logic [W-1:0] len0;
  logic [W-1:0] len1;
  logic         abort;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] cnt;
  logic         cnt_valid;
  logic [1:0]   done;
  logic [1:0]   dbg_state;

  cnt_sched #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .len0        (len0),
    .len1        (len1),
    .abort       (abort),
    .gnt         (gnt),
    .busy        (busy),
    .cnt         (cnt),
    .cnt_valid   (cnt_valid),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mon_cyc = 0;

  // Reference model: each run is a time window. Cycles m_start..m_end-1 show
  // the count (cycle - m_start); cycle m_end is the done pulse; the cycle
  // after that is idle and the pointer moves to the other requester.
  int m_cyc = 0;
  bit m_active = 0;
  int m_start = 0;
  int m_end = 0;
  int m_owner = 0;
  int m_ptr = 0;

  task automatic model_step();
    logic [EW-1:0] e;
    int n;
    int run_len;
    m_cyc++;
    n = m_cyc;
    e = '0;
    if (!reset_n) begin
      m_active = 0;
      m_ptr = 0;
    end else if (m_active && (n - 1 == m_end)) begin
      m_active = 0;
      m_ptr = 1 - m_owner;
    end else if (m_active) begin
      if (abort) m_end = n;
    end else if (req != 2'b00) begin
      m_owner = req[m_ptr] ? m_ptr : 1 - m_ptr;
      run_len = (m_owner == 1) ? int'(len1) : int'(len0);
      m_start = n;
      m_end = n + run_len;
      m_active = 1;
    end
    if (m_active) begin
      e[11] = 1'b1;
      if (n == m_end) begin
        e[8 + m_owner] = 1'b1;
      end else begin
        e[12 + m_owner] = 1'b1;
        e[10] = 1'b1;
        e[7:0] = 8'(n - m_start);
      end
    end
    exp_q.push_back(e);
  endtask

  // driver: inputs change on the falling edge, expectation for the
  // following cycle is pushed at the same time
  task automatic drive(input logic [1:0] r, input logic [W-1:0] l0,
                       input logic [W-1:0] l1, input logic a, input logic rn);
    @(negedge clk);
    req = r;
    len0 = l0;
    len1 = l1;
    abort = a;
    reset_n = rn;
    model_step();
  endtask

  task automatic idle(input int k);
    repeat (k) drive(2'b00, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    repeat (2) drive(2'b00, '0, '0, 1'b0, 1'b0);
    idle(2);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    #1;
    mon_cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {gnt, busy, cnt_valid, done, cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got gnt=%b busy=%b valid=%b done=%b cnt=%0d, want gnt=%b busy=%b valid=%b done=%b cnt=%0d",
                 mon_cyc, act_v[13:12], act_v[11], act_v[10], act_v[9:8], act_v[7:0],
                 exp_v[13:12], exp_v[11], exp_v[10], exp_v[9:8], exp_v[7:0]);
      end
    end
  end

  initial begin
    logic [1:0]   r;
    logic [W-1:0] l0;
    logic [W-1:0] l1;
    logic         a;
    logic         rn;
    req = 2'b00;
    len0 = '0;
    len1 = '0;
    abort = 1'b0;
    reset_n = 1'b0;

    do_reset();

    // single run of 3 for requester 0
    drive(2'b01, 8'd3, 8'd0, 1'b0, 1'b1);
    repeat (6) drive(2'b00, 8'd3, 8'd0, 1'b0, 1'b1);

    // both held: alternating grants, one idle cycle between runs
    do_reset();
    repeat (24) drive(2'b11, 8'd2, 8'd4, 1'b0, 1'b1);
    idle(4);

    // zero-length run for requester 1
    drive(2'b10, 8'd0, 8'd0, 1'b0, 1'b1);
    idle(4);

    // abort at cnt = 4 with requester 1 waiting
    do_reset();
    drive(2'b11, 8'd10, 8'd5, 1'b0, 1'b1);
    repeat (4) drive(2'b11, 8'd10, 8'd5, 1'b0, 1'b1);
    drive(2'b11, 8'd10, 8'd5, 1'b1, 1'b1);
    repeat (4) drive(2'b11, 8'd10, 8'd5, 1'b0, 1'b1);
    drive(2'b00, 8'd10, 8'd5, 1'b0, 1'b1);
    idle(8);

    // reset at cnt = 5, then the first grant favours requester 0
    drive(2'b01, 8'd10, 8'd0, 1'b0, 1'b1);
    repeat (5) drive(2'b01, 8'd10, 8'd0, 1'b0, 1'b1);
    drive(2'b01, 8'd10, 8'd0, 1'b0, 1'b0);
    idle(2);
    drive(2'b11, 8'd3, 8'd3, 1'b0, 1'b1);
    repeat (5) drive(2'b00, 8'd3, 8'd3, 1'b0, 1'b1);
    idle(2);

    // abort on the final count
    drive(2'b01, 8'd3, 8'd0, 1'b0, 1'b1);
    drive(2'b00, 8'd3, 8'd0, 1'b0, 1'b1);
    drive(2'b00, 8'd3, 8'd0, 1'b0, 1'b1);
    drive(2'b00, 8'd3, 8'd0, 1'b1, 1'b1);
    idle(4);

    // full-range run, lengths changed mid-run
    drive(2'b01, 8'd255, 8'd0, 1'b0, 1'b1);
    repeat (260) drive(2'b00, 8'($urandom_range(0, 255)), 8'd0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r  = 2'($urandom_range(0, 3));
      l0 = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      l1 = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      a  = ($urandom_range(0, 15) == 0);
      rn = ($urandom_range(0, 199) != 0);
      drive(r, l0, l1, a, rn);
    end
    idle(3);

    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the counter and run-length width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port req, input, 2 bits: level request per requester, bit i for requester i.
REQ-005 The block SHALL have port len0, input, WIDTH bits: run length for requester 0, in cycles.
REQ-006 The block SHALL have port len1, input, WIDTH bits: run length for requester 1, in cycles.
REQ-007 The block SHALL have port abort, input, 1 bit: terminates the current run early.
REQ-008 The block SHALL have port gnt, output, 2 bits: one-hot grant to the owning requester.
REQ-009 The block SHALL have port busy, output, 1 bit: high when the FSM is in RUN or DONE.
REQ-010 The block SHALL have port cnt, output, WIDTH bits: shared counter value, gated.
REQ-011 The block SHALL have port cnt_valid, output, 1 bit: cnt carries a live count.
REQ-012 The block SHALL have port done, output, 2 bits: one-cycle completion pulse per requester.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with req != 0, the FSM SHALL select the winner by round-robin from pointer ptr: requester ptr wins if it is requesting, otherwise the other requester wins.
REQ-015 On selection, the FSM SHALL latch the winner's len into len_q, clear the internal counter to 0, and go to RUN if len_q != 0 or to DONE if len_q == 0.
REQ-016 Latency SHALL be as follows: req seen in IDLE at cycle T gives gnt and, if len != 0, cnt_valid both high at T+1.
REQ-017 In RUN, cnt_valid SHALL be 1 and the counter SHALL increment by 1 per cycle, so cnt shows 0, 1, ..., len_q-1 on consecutive cycles.
REQ-018 When the counter equals len_q-1 in RUN, the FSM SHALL go to DONE on the next edge, giving exactly len_q valid cycles.
REQ-019 The counter SHALL be WIDTH bits wide, with no wrap inside a run; len_q = 2^WIDTH-1 yields a maximum of 2^WIDTH-1 cycles.
REQ-020 When cnt_valid is 0, cnt SHALL be driven to all zeros.
REQ-021 In DONE, done[winner] SHALL be 1 for exactly one cycle, gnt SHALL be 0, cnt_valid SHALL be 0, ptr SHALL be set to the other requester, and the next state SHALL be IDLE.
REQ-022 gnt[winner] SHALL be 1 only in RUN; a len == 0 grant therefore produces a done pulse with no gnt cycle and no valid cycles.
REQ-023 abort high in RUN SHALL force DONE on the next edge, and cnt_valid SHALL drop in that cycle.
REQ-024 abort SHALL be ignored in IDLE and in DONE.
REQ-025 abort high in the same cycle as the final count SHALL give identical behaviour: DONE follows and there is a single done pulse.
REQ-026 Deassertion of req during RUN SHALL be ignored; the run completes or is aborted normally.
REQ-027 Changes to len0 or len1 after latching SHALL have no effect on the current run.
REQ-028 A request still held after its done pulse SHALL be treated as a new request and arbitrated in the following IDLE cycle.
REQ-029 Every run SHALL be followed by at least one IDLE cycle, so the minimum spacing between grants is one IDLE cycle.
REQ-030 gnt SHALL always be one-hot or zero, and done SHALL always be one-hot or zero.

Reset
REQ-031 With reset_n = 0 at a clk edge, the block SHALL set state = IDLE, ptr = 0, counter = 0 and len_q = 0.
REQ-032 During and after reset, the outputs SHALL be gnt = 0, done = 0, busy = 0, cnt_valid = 0 and cnt = 0.
REQ-033 Reset asserted mid-RUN SHALL abandon the run with no done pulse; the first grant after reset SHALL favour requester 0.

Verification
REQ-034 The bench SHALL check: after reset, req = 01 and len0 = 3 -> gnt = 01 for 3 cycles with cnt = 0, 1, 2 and cnt_valid = 1, then done = 01 for 1 cycle, then IDLE.
REQ-035 The bench SHALL check: req = 11 held, len0 = 2, len1 = 4 -> grants alternate 0, 1, 0, 1 with one IDLE cycle between runs and cnt restarting at 0 on each run.
REQ-036 The bench SHALL check: req = 10 and len1 = 0 -> done = 10 pulse one cycle after selection, with gnt and cnt_valid never high.
REQ-037 The bench SHALL check: len0 = 10, abort pulsed while cnt = 4 -> cnt_valid falls, a single done = 01 pulse, and the next grant goes to requester 1 if it is requesting.
REQ-038 The bench SHALL check: reset_n = 0 applied while cnt = 5 -> all outputs are 0 the next cycle, with no done pulse.
REQ-039 The bench SHALL check: len0 = 255 -> exactly 255 valid cycles, with cnt ending at 254 and no wrap.
